// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants plus hazard controller types.
// Opcodes follow the RV32I base encoding.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LDTYPE = 7'b0000011;
    localparam logic [6:0] OP_STYPE  = 7'b0100011;
    localparam logic [6:0] OP_BTYPE  = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  ld;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hctrl_state_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // x0 is hardwired, so it can never carry a dependency.
    function automatic logic src_hit(
        input logic                  use_rs,
        input logic [REG_ADDR_W-1:0] rs,
        input sb_entry_t             e
    );
        return use_rs && (rs != '0) && e.valid && e.we && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_decode.sv
// ID-stage operand/usage decoder for hazard detection.
// Purely combinational; funct fields are irrelevant here.
module hazard_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [`INSTR_SIZE-1:0] instr_in,
    output logic [REG_ADDR_W-1:0]  rs1,
    output logic [REG_ADDR_W-1:0]  rs2,
    output logic [REG_ADDR_W-1:0]  rd,
    output logic                   uses_rs1,
    output logic                   uses_rs2,
    output logic                   writes_rd,
    output logic                   is_load
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = instr_in[6:0];
    assign rd          = instr_in[11:7];
    assign rs1         = instr_in[19:15];
    assign rs2         = instr_in[24:20];
    assign unused_bits = ^{instr_in[`INSTR_SIZE-1:25], instr_in[14:12]};

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        unique case (1'b1)
            (opcode == OP_RTYPE): begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            (opcode == OP_ITYPE): begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            (opcode == OP_LDTYPE): begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            (opcode == OP_STYPE),
            (opcode == OP_BTYPE): begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            (opcode == OP_LUI),
            (opcode == OP_AUIPC),
            (opcode == OP_JAL): begin
                writes_rd = 1'b1;
            end
            (opcode == OP_JALR): begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, branch flush, memory freeze.
// Outputs are combinational so the cu can act on them in the same cycle.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN     = 1'b1,
    parameter bit WB_BYPASS  = 1'b1,
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [`INSTR_SIZE-1:0] instr_in,
    input  logic                   branch_taken,
    input  logic                   dmem_ready,
    output logic                   stall,
    output logic                   chng2nop,
    output logic                   flush,
    output logic                   freeze,
    output logic [CNT_W-1:0]       hazard_cnt
);

    localparam logic [2:0] BR_RELOAD = 3'(BR_PENALTY - 1);

    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  writes_rd;
    logic                  is_load;

    hazard_decode u_decode (
        .instr_in  (instr_in),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (id_rd),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load)
    );

    sb_entry_t    id_e;
    sb_entry_t    ex_q;
    sb_entry_t    mem_q;
    sb_entry_t    wb_q;
    hctrl_state_t state_q;
    logic [2:0]   br_cnt_q;
    logic         hit_ex;
    logic         hit_mem;
    logic         hit_wb;
    logic         raw;
    logic         br_act;
    logic         raw_stall;
    logic         unused_ld;

    assign id_e = '{
        valid: 1'b1,
        rd:    id_rd,
        we:    writes_rd && (id_rd != '0),
        ld:    is_load
    };

    assign hit_ex  = src_hit(uses_rs1, rs1, ex_q)
                  || src_hit(uses_rs2, rs2, ex_q);
    assign hit_mem = src_hit(uses_rs1, rs1, mem_q)
                  || src_hit(uses_rs2, rs2, mem_q);
    assign hit_wb  = src_hit(uses_rs1, rs1, wb_q)
                  || src_hit(uses_rs2, rs2, wb_q);

    // With forwarding only a load still in EX cannot be bypassed.
    assign raw = FWD_EN
               ? (ex_q.ld && hit_ex)
               : (hit_ex || hit_mem || (!WB_BYPASS && hit_wb));

    assign unused_ld = mem_q.ld ^ wb_q.ld;

    assign br_act    = branch_taken || (state_q == FLUSH);
    assign raw_stall = nrst && dmem_ready && !br_act && raw;

    assign freeze   = nrst && !dmem_ready;
    assign flush    = nrst && dmem_ready && br_act;
    assign chng2nop = nrst && dmem_ready && (br_act || raw);
    assign stall    = nrst && (!dmem_ready || (!br_act && raw));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else if (dmem_ready) begin
            ex_q  <= chng2nop ? SB_EMPTY : id_e;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= RUN;
            br_cnt_q <= '0;
        end else if (dmem_ready) begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken && (BR_PENALTY > 1)) begin
                        state_q  <= FLUSH;
                        br_cnt_q <= BR_RELOAD;
                    end
                end
                FLUSH: begin
                    if (branch_taken) begin
                        br_cnt_q <= BR_RELOAD;
                    end else if (br_cnt_q == 3'd1) begin
                        state_q  <= RUN;
                        br_cnt_q <= '0;
                    end else begin
                        br_cnt_q <= br_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    br_cnt_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hazard_cnt <= '0;
        end else if (raw_stall && (hazard_cnt != '1)) begin
            hazard_cnt <= hazard_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameter sets share one stimulus stream,
// each checked every cycle against an issue-history model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] instr = 32'h0000_0013;
    logic        bt = 1'b0;
    logic        dr = 1'b1;
    logic [2:0]  st;
    logic [2:0]  cn;
    logic [2:0]  fl;
    logic [2:0]  fz;
    logic [15:0] hc0;
    logic [1:0]  hc1;
    logic [15:0] hc2;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    hazard_ctrl u0 (
        .clk(clk), .nrst(nrst), .instr_in(instr),
        .branch_taken(bt), .dmem_ready(dr),
        .stall(st[0]), .chng2nop(cn[0]), .flush(fl[0]),
        .freeze(fz[0]), .hazard_cnt(hc0)
    );

    hazard_ctrl #(
        .FWD_EN(1'b0), .WB_BYPASS(1'b0), .BR_PENALTY(3), .CNT_W(2)
    ) u1 (
        .clk(clk), .nrst(nrst), .instr_in(instr),
        .branch_taken(bt), .dmem_ready(dr),
        .stall(st[1]), .chng2nop(cn[1]), .flush(fl[1]),
        .freeze(fz[1]), .hazard_cnt(hc1)
    );

    hazard_ctrl #(
        .FWD_EN(1'b0), .WB_BYPASS(1'b1), .BR_PENALTY(1), .CNT_W(16)
    ) u2 (
        .clk(clk), .nrst(nrst), .instr_in(instr),
        .branch_taken(bt), .dmem_ready(dr),
        .stall(st[2]), .chng2nop(cn[2]), .flush(fl[2]),
        .freeze(fz[2]), .hazard_cnt(hc2)
    );

    bit p_fwd[3]  = '{1'b1, 1'b0, 1'b0};
    bit p_wbb[3]  = '{1'b1, 1'b0, 1'b1};
    int p_pen[3]  = '{2, 3, 1};
    int p_max[3]  = '{65535, 3, 65535};

    typedef struct {
        bit v;
        bit we;
        bit ld;
        int rd;
    } prod_t;

    // hist[k][d]: what entered EX d+1 pipeline steps ago
    prod_t hist[3][3];
    int    remain[3];
    int    mcnt[3];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int hcv(input int k);
        case (k)
            0: return int'(hc0);
            1: return int'(hc1);
            default: return int'(hc2);
        endcase
    endfunction

    function automatic void dec(
        input  logic [31:0] i,
        output bit u1, output bit u2, output bit wr, output bit ld,
        output int rd, output int r1, output int r2
    );
        u1 = 0; u2 = 0; wr = 0; ld = 0;
        rd = int'(i[11:7]);
        r1 = int'(i[19:15]);
        r2 = int'(i[24:20]);
        case (i[6:0])
            7'b0110011: begin u1 = 1; u2 = 1; wr = 1; end
            7'b0010011: begin u1 = 1; wr = 1; end
            7'b0000011: begin u1 = 1; wr = 1; ld = 1; end
            7'b0100011: begin u1 = 1; u2 = 1; end
            7'b1100011: begin u1 = 1; u2 = 1; end
            7'b0110111: wr = 1;
            7'b0010111: wr = 1;
            7'b1101111: wr = 1;
            7'b1100111: begin u1 = 1; wr = 1; end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            remain[k] = 0;
            mcnt[k] = 0;
            for (int d = 0; d < 3; d++) hist[k][d] = '{0, 0, 0, 0};
        end
    endtask

    always @(negedge clk) begin
        if (!nrst) begin
            model_reset();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("u%0d_rst_stall", k), int'(st[k]), 0);
                chk($sformatf("u%0d_rst_nop", k), int'(cn[k]), 0);
                chk($sformatf("u%0d_rst_flush", k), int'(fl[k]), 0);
                chk($sformatf("u%0d_rst_freeze", k), int'(fz[k]), 0);
                chk($sformatf("u%0d_rst_cnt", k), hcv(k), 0);
            end
        end else begin
            bit u1, u2, wr, ld, raw, br, inwin;
            bit e_st, e_cn, e_fl, e_fz;
            int rd, r1, r2;
            dec(instr, u1, u2, wr, ld, rd, r1, r2);
            for (int k = 0; k < 3; k++) begin
                raw = 0;
                for (int d = 0; d < 3; d++) begin
                    inwin = p_fwd[k] ? (d == 0 && hist[k][d].ld)
                                     : (d < 2 || !p_wbb[k]);
                    if (inwin && hist[k][d].v && hist[k][d].we &&
                        ((u1 && hist[k][d].rd == r1) ||
                         (u2 && hist[k][d].rd == r2)))
                        raw = 1;
                end
                br = bt || remain[k] > 0;
                e_fz = !dr;
                e_fl = dr && br;
                e_cn = dr && (br || raw);
                e_st = !dr || (!br && raw);
                chk($sformatf("u%0d_stall", k), int'(st[k]), int'(e_st));
                chk($sformatf("u%0d_chng2nop", k), int'(cn[k]), int'(e_cn));
                chk($sformatf("u%0d_flush", k), int'(fl[k]), int'(e_fl));
                chk($sformatf("u%0d_freeze", k), int'(fz[k]), int'(e_fz));
                chk($sformatf("u%0d_cnt", k), hcv(k), mcnt[k]);
                if (dr) begin
                    if (!br && raw && mcnt[k] < p_max[k]) mcnt[k]++;
                    if (bt) remain[k] = p_pen[k] - 1;
                    else if (remain[k] > 0) remain[k]--;
                    hist[k][2] = hist[k][1];
                    hist[k][1] = hist[k][0];
                    if (e_cn) hist[k][0] = '{0, 0, 0, 0};
                    else hist[k][0] = '{1, wr && rd != 0, ld, rd};
                end
            end
        end
    end

    function automatic logic [31:0] op_r(input int d, input int a, input int b);
        return {7'd0, 5'(b), 5'(a), 3'd0, 5'(d), 7'b0110011};
    endfunction

    function automatic logic [31:0] op_ld(input int d, input int a);
        return {12'd0, 5'(a), 3'b010, 5'(d), 7'b0000011};
    endfunction

    function automatic logic [31:0] op_beq(input int a, input int b);
        return {7'd0, 5'(b), 5'(a), 3'd0, 5'd0, 7'b1100011};
    endfunction

    task automatic step(input logic [31:0] i, input logic b, input logic d);
        @(posedge clk);
        #1;
        instr = i;
        bt = b;
        dr = d;
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step(NOP, 1'b0, 1'b1);
        step(NOP, 1'b0, 1'b1);
        nrst = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [6:0] op;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b1100111, 7'b1111111};
        op = ops[$urandom_range(0, 9)];
        return {7'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        model_reset();
        step(NOP, 1'b0, 1'b1);
        chk("reset_stall", int'(st[0]), 0);
        chk("reset_cnt", int'(hc0), 0);
        do_reset();

        // load-use with forwarding: exactly one stall cycle
        step(op_ld(4, 1), 1'b0, 1'b1);
        step(op_r(7, 4, 5), 1'b0, 1'b1);
        chk("t1_stall", int'(st[0]), 1);
        chk("t1_nop", int'(cn[0]), 1);
        step(op_r(7, 4, 5), 1'b0, 1'b1);
        chk("t1_release", int'(st[0]), 0);
        chk("t1_cnt", int'(hc0), 1);

        // x0 destinations and forwarded ALU results never stall
        do_reset();
        step(op_ld(0, 1), 1'b0, 1'b1);
        step(op_r(7, 0, 5), 1'b0, 1'b1);
        chk("t2_x0", int'(st[0]), 0);
        step(op_r(4, 3, 2), 1'b0, 1'b1);
        step(op_r(7, 4, 5), 1'b0, 1'b1);
        chk("t2_fwd", int'(st[0]), 0);
        chk("t2_cnt", int'(hc0), 0);

        // no forwarding: 2 stalls with WB bypass, 3 without
        do_reset();
        step(op_r(4, 3, 2), 1'b0, 1'b1);
        step(op_beq(4, 2), 1'b0, 1'b1);
        chk("t3_u2_s1", int'(st[2]), 1);
        step(op_beq(4, 2), 1'b0, 1'b1);
        chk("t3_u2_s2", int'(st[2]), 1);
        step(op_beq(4, 2), 1'b0, 1'b1);
        chk("t3_u2_s3", int'(st[2]), 0);
        chk("t3_u1_s3", int'(st[1]), 1);
        step(op_beq(4, 2), 1'b0, 1'b1);
        chk("t3_u1_s4", int'(st[1]), 0);
        chk("t3_u2_cnt", int'(hc2), 2);
        chk("t3_u1_cnt", int'(hc1), 3);
        for (int n = 0; n < 3; n++) step(NOP, 1'b0, 1'b1);
        step(op_r(4, 3, 2), 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) step(op_beq(4, 2), 1'b0, 1'b1);
        chk("t6_sat", int'(hc1), 3);
        chk("t3_u2_cnt2", int'(hc2), 4);

        // taken branch masks a simultaneous load-use hazard
        do_reset();
        step(op_ld(4, 1), 1'b0, 1'b1);
        step(op_r(7, 4, 5), 1'b1, 1'b1);
        chk("t4_flush1", int'(fl[0]), 1);
        chk("t4_nop1", int'(cn[0]), 1);
        chk("t4_stall1", int'(st[0]), 0);
        step(op_r(7, 4, 5), 1'b0, 1'b1);
        chk("t4_flush2", int'(fl[0]), 1);
        chk("t4_stall2", int'(st[0]), 0);
        step(op_r(7, 4, 5), 1'b0, 1'b1);
        chk("t4_flush3", int'(fl[0]), 0);
        chk("t4_cnt", int'(hc0), 0);

        // memory wait freezes, then the load-use stall follows
        do_reset();
        step(op_ld(4, 1), 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step(op_r(7, 4, 5), 1'b0, 1'b0);
            chk("t5_freeze", int'(fz[0]), 1);
            chk("t5_stall", int'(st[0]), 1);
            chk("t5_nop", int'(cn[0]), 0);
        end
        step(op_r(7, 4, 5), 1'b0, 1'b1);
        chk("t5_raw", int'(st[0]), 1);
        chk("t5_rawnop", int'(cn[0]), 1);
        step(op_r(7, 4, 5), 1'b0, 1'b1);
        chk("t5_done", int'(st[0]), 0);
        chk("t5_cnt", int'(hc0), 1);

        // reset in the middle of a flush leaves nothing behind
        do_reset();
        step(NOP, 1'b1, 1'b1);
        step(NOP, 1'b0, 1'b1);
        chk("t6_flush2", int'(fl[0]), 1);
        nrst = 1'b0;
        #1;
        chk("t6_rst_flush", int'(fl[0]), 0);
        chk("t6_rst_nop", int'(cn[0]), 0);
        chk("t6_rst_u1", int'(fl[1]), 0);
        step(NOP, 1'b0, 1'b1);
        nrst = 1'b1;
        step(NOP, 1'b0, 1'b1);
        chk("t6_noresid0", int'(fl[0]), 0);
        chk("t6_noresid1", int'(fl[1]), 0);

        for (int n = 0; n < 3000; n++) begin
            step(rand_instr(), $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
